// File: rtl/uart_rx_datapath.sv
// 16x-oversampled UART receiver: synchronises the line, frames LSB-first bytes with optional
// parity and one or two stop bits, and presents each byte through a one-entry output register.
module uart_rx_datapath #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_serial,
    input  logic [1:0]            parity_sel,
    input  logic                  stop_bits,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_parity_err,
    output logic                  rx_frame_err,
    output logic                  rx_overrun,
    output logic                  rx_busy
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SCNT_W  = $clog2(OVERSAMPLE);
    localparam int BCNT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SCNT_W-1:0] SCNT_MID  = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic                  prev_q, prev_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [SCNT_W-1:0]     scnt_q, scnt_d;
    logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [1:0]            psel_q, psel_d;
    logic                  stop2_q, stop2_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_perr_q, rx_perr_d;
    logic                  rx_ferr_q, rx_ferr_d;
    logic                  rx_overrun_q, rx_overrun_d;

    logic rx_s;
    logic tick;
    logic sample;

    assign rx_s   = sync2_q;
    assign tick   = (state_q != IDLE) && (div_q == DIV_LAST);
    assign sample = tick && (scnt_q == SCNT_LAST);

    always_comb begin
        state_d      = state_q;
        sync1_d      = rx_serial;
        sync2_d      = sync1_q;
        prev_d       = sync2_q;
        div_d        = div_q;
        scnt_d       = scnt_q;
        bcnt_d       = bcnt_q;
        shift_d      = shift_q;
        psel_d       = psel_q;
        stop2_d      = stop2_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        rx_perr_d    = rx_perr_q;
        rx_ferr_d    = rx_ferr_q;
        rx_overrun_d = 1'b0;

        if (state_q == IDLE || tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end

        if (state_q == IDLE) begin
            scnt_d = '0;
        end else if (tick) begin
            scnt_d = (scnt_q == SCNT_LAST) ? '0 : scnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                // Frame format is latched here so mid-frame changes cannot corrupt the frame
                if (prev_q && !rx_s) begin
                    state_d = START;
                    psel_d  = parity_sel;
                    stop2_d = stop_bits;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    bcnt_d  = '0;
                end
            end
            START: begin
                if (tick && scnt_q == SCNT_MID) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        scnt_d  = '0;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shift_d = DATA_WIDTH'({rx_s, shift_q} >> 1);
                    if (bcnt_q == BCNT_LAST) begin
                        bcnt_d  = '0;
                        state_d = (psel_q == 2'b01 || psel_q == 2'b10) ? PARITY : STOP1;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (sample) begin
                    perr_d  = ((^shift_q) ^ rx_s) != (psel_q == 2'b01);
                    state_d = STOP1;
                end
            end
            STOP1: begin
                if (sample) begin
                    ferr_d  = ferr_q | ~rx_s;
                    state_d = stop2_q ? STOP2 : DONE;
                end
            end
            STOP2: begin
                if (sample) begin
                    ferr_d  = ferr_q | ~rx_s;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A completed frame only replaces the held byte if that byte is gone or leaving now
        if (state_q == DONE) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_perr_d  = perr_q;
                rx_ferr_d  = ferr_q;
                rx_valid_d = 1'b1;
            end else begin
                rx_overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            prev_q       <= 1'b1;
            div_q        <= '0;
            scnt_q       <= '0;
            bcnt_q       <= '0;
            shift_q      <= '0;
            psel_q       <= 2'b00;
            stop2_q      <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_perr_q    <= 1'b0;
            rx_ferr_q    <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            div_q        <= div_d;
            scnt_q       <= scnt_d;
            bcnt_q       <= bcnt_d;
            shift_q      <= shift_d;
            psel_q       <= psel_d;
            stop2_q      <= stop2_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_perr_q    <= rx_perr_d;
            rx_ferr_q    <= rx_ferr_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;
    assign rx_overrun    = rx_overrun_q;
    assign rx_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_datapath.sv
// Bench for uart_rx_datapath: frames are built bit by bit from the line protocol rules and the
// bytes the receiver hands over are compared against a queue of expected frames.
module tb_uart_rx_datapath;

    localparam int BIT_CLKS = 16;

    logic       clk;
    logic       reset_n;
    logic       rx_serial;
    logic [1:0] parity_sel;
    logic       stop_bits;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    uart_rx_datapath #(
        .CLK_FREQ  (1_600_000),
        .BAUD_RATE (100_000),
        .OVERSAMPLE(16),
        .DATA_WIDTH(8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_serial    (rx_serial),
        .parity_sel   (parity_sel),
        .stop_bits    (stop_bits),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_parity_err(rx_parity_err),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_busy      (rx_busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } frame_t;

    frame_t expQ[$];
    int     testsRun     = 0;
    int     testsFailed  = 0;
    int     cyc          = 0;
    int     startCyc     = 0;
    int     validRises   = 0;
    int     lastRiseCyc  = 0;
    int     overrunCount = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun = testsRun + 1;
        if (observed !== expected) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Consumer side: every handshake must match the oldest outstanding expected frame
    initial begin
        logic   prevValid;
        frame_t f;
        prevValid = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_overrun) overrunCount = overrunCount + 1;
            if (rx_valid && !prevValid) begin
                validRises  = validRises + 1;
                lastRiseCyc = cyc;
            end
            prevValid = rx_valid;
            if (!reset_n && rx_valid && rx_ready) begin
                checkOutput("byte_expected", 32'(expQ.size() > 0), 32'd1);
                if (expQ.size() > 0) begin
                    f = expQ.pop_front();
                    checkOutput("rx_data", 32'(rx_data), 32'(f.data));
                    checkOutput("parity_err", 32'(rx_parity_err), 32'(f.perr));
                    checkOutput("frame_err", 32'(rx_frame_err), 32'(f.ferr));
                end
            end
        end
    end

    task automatic driveBit(input logic b);
        rx_serial = b;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic [1:0] ps, input logic sb,
                                 input logic flipPar, input logic stopLow, input int gap,
                                 input logic expectByte);
        logic   parOn;
        logic   pbit;
        frame_t f;
        parOn = (ps == 2'b01) || (ps == 2'b10);
        pbit  = (ps == 2'b01) ? ~(^d) : (^d);
        if (flipPar) pbit = ~pbit;
        if (expectByte) begin
            f.data = d;
            f.perr = parOn && flipPar;
            f.ferr = stopLow;
            expQ.push_back(f);
        end
        @(posedge clk);
        #1;
        parity_sel = ps;
        stop_bits  = sb;
        startCyc   = cyc;
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(d[i]);
        if (parOn) driveBit(pbit);
        driveBit(~stopLow);
        if (sb) driveBit(1'b1);
        if (!stopLow) rx_serial = 1'b1;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    initial begin
        int riseBase;
        int ovBase;
        int busyCnt;

        reset_n    = 1'b1;
        rx_serial  = 1'b1;
        rx_ready   = 1'b1;
        parity_sel = 2'b00;
        stop_bits  = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("reset_flags",
                    32'({rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_busy}), 32'd0);
        checkOutput("reset_data", 32'(rx_data), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] 0xA5 8N1");
        riseBase = validRises;
        applyStimulus(8'hA5, 2'b00, 1'b0, 1'b0, 1'b0, 20, 1'b1);
        checkOutput("a5_one_pulse", 32'(validRises - riseBase), 32'd1);
        checkOutput("a5_latency", 32'(lastRiseCyc - startCyc), 32'd156);

        $display("[TB] 0x3C even parity, two stop bits");
        applyStimulus(8'h3C, 2'b10, 1'b1, 1'b0, 1'b0, 10, 1'b1);
        applyStimulus(8'h3C, 2'b10, 1'b1, 1'b1, 1'b0, 10, 1'b1);

        $display("[TB] 0x55 with low stop bit");
        riseBase = validRises;
        applyStimulus(8'h55, 2'b00, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        repeat (32) @(posedge clk);
        #1;
        checkOutput("stop_low_idle", 32'(rx_busy), 32'd0);
        checkOutput("stop_low_one_byte", 32'(validRises - riseBase), 32'd1);
        rx_serial = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        $display("[TB] break");
        applyStimulus(8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 40, 1'b1);
        checkOutput("break_idle", 32'(rx_busy), 32'd0);
        rx_serial = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        $display("[TB] overrun with consumer stalled");
        ovBase   = overrunCount;
        rx_ready = 1'b0;
        applyStimulus(8'h11, 2'b00, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        applyStimulus(8'h22, 2'b00, 1'b0, 1'b0, 1'b0, 20, 1'b0);
        checkOutput("overrun_pulses", 32'(overrunCount - ovBase), 32'd1);
        checkOutput("overrun_held_valid", 32'(rx_valid), 32'd1);
        checkOutput("overrun_held_data", 32'(rx_data), 32'h11);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("valid_drop", 32'(rx_valid), 32'd0);
        repeat (10) @(posedge clk);
        #1;

        $display("[TB] 5-clk glitch");
        riseBase = validRises;
        busyCnt  = 0;
        rx_serial = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rx_serial = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (rx_busy) busyCnt = busyCnt + 1;
        end
        checkOutput("glitch_busy_seen", 32'(busyCnt > 0), 32'd1);
        checkOutput("glitch_busy_bound", 32'(busyCnt <= 8), 32'd1);
        checkOutput("glitch_no_byte", 32'(validRises - riseBase), 32'd0);
        checkOutput("glitch_idle", 32'(rx_busy), 32'd0);

        $display("[TB] randomized frames");
        for (int n = 0; n < 24; n++) begin
            applyStimulus(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 4) == 0), $urandom_range(1, 24), 1'b1);
            rx_serial = 1'b1;
        end
        repeat (20) @(posedge clk);
        #1;

        $display("[TB] reset during 0xFF data");
        rx_serial = 1'b0;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
        rx_serial = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("busy_mid_frame", 32'(rx_busy), 32'd1);
        reset_n = 1'b1;
        #1;
        checkOutput("abort_flags",
                    32'({rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_busy}), 32'd0);
        checkOutput("abort_data", 32'(rx_data), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        riseBase = validRises;
        applyStimulus(8'h81, 2'b01, 1'b0, 1'b0, 1'b0, 20, 1'b1);
        checkOutput("post_reset_byte", 32'(validRises - riseBase), 32'd1);

        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        checkOutput("total_overruns", 32'(overrunCount), 32'd1);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
